// File: rtl/umtrx_stream_combiner_pkg.sv
// Shared definitions for the UmTRX stream combiner: beat framing, arbitration modes,
// setting-register offsets and the combiner FSM encoding.
package umtrx_stream_combiner_pkg;

  localparam int TLAST_BIT = 33;

  localparam logic MODE_RR   = 1'b0;
  localparam logic MODE_PRIO = 1'b1;

  localparam int REG_CTRL = 0;
  localparam int REG_SEL  = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_PASS
  } state_t;

endpackage

// File: rtl/umtrx_rr_arbiter.sv
// Combinational N-way arbiter: round-robin starting after last_grant, or fixed
// priority with the lowest index winning.
module umtrx_rr_arbiter
  import umtrx_stream_combiner_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic          mode,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] grant,
  output logic          any
);

  int   idx;
  logic found;

  assign any = |req;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    if (mode == MODE_PRIO) begin
      for (int i = N-1; i >= 0; i--)
        if (req[i]) grant = IW'(i);
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(last_grant) + k) % N;
        if (!found && req[idx]) begin
          grant = IW'(idx);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/umtrx_stream_combiner.sv
// Packet-atomic N-input combiner: arbitrates whole packets onto one registered output,
// drains disabled ports so they never stall, and counts forwarded packets per port.
module umtrx_stream_combiner
  import umtrx_stream_combiner_pkg::*;
#(
  parameter int NUM_PORTS = 8,
  parameter int WIDTH     = 36,
  parameter int BASE      = 0,
  parameter int CNT_W     = 16
) (
  input  logic                       stream_clk,
  input  logic                       stream_rst_n,
  input  logic                       stream_clr,
  input  logic                       set_stb,
  input  logic [7:0]                 set_addr,
  input  logic [31:0]                set_data,
  input  logic [NUM_PORTS*WIDTH-1:0] inp_data,
  input  logic [NUM_PORTS-1:0]       inp_valid,
  output logic [NUM_PORTS-1:0]       inp_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                status
);

  localparam int IW = $clog2(NUM_PORTS);
  localparam logic [7:0] ADDR_CTRL = 8'(BASE + REG_CTRL);
  localparam logic [7:0] ADDR_SEL  = 8'(BASE + REG_SEL);

  state_t state, state_nxt;
  logic [IW-1:0] grant, last_grant, arb_grant;
  logic          arb_any;
  logic          mode;
  logic [3:0]    sel_port;
  logic [NUM_PORTS-1:0] enable, drain, in_pkt, req, acc, port_last;
  logic [NUM_PORTS-1:0][CNT_W-1:0] cnt;
  logic [WIDTH-1:0] pass_beat;
  logic          pass_rdy, pass_vld, pass_acc, pass_last;
  logic [15:0]   sel_cnt;
  logic          unused_set;

  assign unused_set = ^set_data;

  assign req       = inp_valid & enable & ~drain;
  assign pass_rdy  = (state == S_PASS) && (!out_valid || out_ready);
  assign pass_acc  = pass_rdy && pass_vld;
  assign pass_last = pass_beat[TLAST_BIT];
  assign acc       = inp_valid & inp_ready;

  umtrx_rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_arb (
    .req        (req),
    .mode       (mode),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .any        (arb_any)
  );

  always_comb begin
    pass_beat = '0;
    pass_vld  = 1'b0;
    inp_ready = drain;
    port_last = '0;
    sel_cnt   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_last[i] = inp_data[i*WIDTH + TLAST_BIT];
      if (grant == IW'(i)) begin
        pass_beat    = inp_data[i*WIDTH +: WIDTH];
        pass_vld     = inp_valid[i];
        inp_ready[i] = drain[i] | pass_rdy;
      end
      if (sel_port == 4'(i)) sel_cnt = 16'(cnt[i]);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|req) state_nxt = S_ARB;
      S_ARB:   state_nxt = arb_any ? S_PASS : S_IDLE;
      S_PASS:  if (pass_acc && pass_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign status = {state != S_IDLE, 3'b0, (state != S_IDLE) ? 4'(grant) : 4'd0, 8'b0, sel_cnt};

  // Settings survive stream_clr; only a full reset restores them.
  always_ff @(posedge stream_clk) begin
    if (!stream_rst_n) begin
      enable   <= '1;
      mode     <= MODE_RR;
      sel_port <= '0;
    end else if (set_stb) begin
      if (set_addr == ADDR_CTRL) begin
        enable <= set_data[NUM_PORTS-1:0];
        mode   <= set_data[31];
      end
      if (set_addr == ADDR_SEL) sel_port <= set_data[3:0];
    end
  end

  always_ff @(posedge stream_clk) begin
    if (!stream_rst_n || stream_clr) begin
      state      <= S_IDLE;
      grant      <= '0;
      last_grant <= IW'(NUM_PORTS - 1);
      out_valid  <= 1'b0;
      out_data   <= '0;
      cnt        <= '0;
      in_pkt     <= '0;
      drain      <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_ARB && arb_any) grant <= arb_grant;
      if (pass_acc) begin
        out_data  <= pass_beat;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (pass_acc && pass_last) begin
        last_grant <= grant;
        cnt[grant] <= cnt[grant] + CNT_W'(1);
      end
      // Drain state only moves between packets, and never under the port being forwarded.
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (acc[i]) in_pkt[i] <= !port_last[i];
        if (!in_pkt[i] && !(acc[i] && !port_last[i]) && !(state == S_PASS && grant == IW'(i)))
          drain[i] <= !enable[i];
      end
    end
  end

endmodule

// File: tb/tb_umtrx_stream_combiner.sv
// Directed bench for umtrx_stream_combiner: packet sources per port, an output beat queue,
// hand-computed expectations for ordering, priority, drain, backpressure, reset and wrap.
module tb_umtrx_stream_combiner;

  localparam int NP    = 8;
  localparam int W     = 36;
  localparam int CNT_W = 4;

  logic            clk = 1'b0;
  logic            rst_n, clr, set_stb, out_valid, out_ready;
  logic [7:0]      set_addr;
  logic [31:0]     set_data, status;
  logic [NP*W-1:0] inp_data;
  logic [NP-1:0]   inp_valid, inp_ready;
  logic [W-1:0]    out_data;

  int checks = 0;
  int errors = 0;
  int src_left[NP], src_len[NP], src_beat[NP], src_seq[NP];
  logic tog;
  logic [W-1:0] outq[$];

  umtrx_stream_combiner #(.NUM_PORTS(NP), .WIDTH(W), .BASE(0), .CNT_W(CNT_W)) dut (
    .stream_clk   (clk),
    .stream_rst_n (rst_n),
    .stream_clr   (clr),
    .set_stb      (set_stb),
    .set_addr     (set_addr),
    .set_data     (set_data),
    .inp_data     (inp_data),
    .inp_valid    (inp_valid),
    .inp_ready    (inp_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .status       (status)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_beat(input int port, input int seq, input int idx, input logic last);
    logic [W-1:0] b;
    b = '0;
    b[33]    = last;
    b[31:28] = 4'(port);
    b[27:16] = 12'(seq);
    b[15:0]  = 16'(idx);
    return b;
  endfunction

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      inp_valid[i] = src_left[i] > 0;
      inp_data[i*W +: W] = mk_beat(i, src_seq[i], src_beat[i], src_beat[i] == src_len[i] - 1);
    end
  endtask

  task automatic tick();
    logic [NP-1:0] fire;
    logic ofire;
    @(negedge clk);
    fire  = inp_valid & inp_ready;
    ofire = out_valid & out_ready;
    if (ofire) outq.push_back(out_data);
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (fire[i]) begin
        if (src_beat[i] == src_len[i] - 1) begin
          src_beat[i] = 0;
          src_seq[i]++;
          src_left[i]--;
        end else begin
          src_beat[i]++;
        end
      end
    end
    if (tog) out_ready = !out_ready;
    drive();
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    tick();
    set_stb = 1'b0;
  endtask

  task automatic run_until(input int nbeats, input int budget, input string tag);
    int n = 0;
    while (outq.size() < nbeats && n < budget) begin tick(); n++; end
    chk(tag, outq.size(), nbeats);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    outq.delete();
  endtask

  task automatic start_src(input int p, input int len, input int pkts);
    src_len[p] = len; src_left[p] = pkts; src_beat[p] = 0; src_seq[p] = 0;
    drive();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; clr = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    out_ready = 1'b1; tog = 1'b0; inp_data = '0; inp_valid = '0;
    for (int i = 0; i < NP; i++) begin src_left[i] = 0; src_len[i] = 1; src_beat[i] = 0; src_seq[i] = 0; end
    drive();
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_inp_ready", inp_ready, 0);
    chk("rst_status", status, 0);
    rst_n = 1'b1;
    tick();

    // Round robin over all ports, 2 packets of 3 beats each.
    for (int i = 0; i < NP; i++) start_src(i, 3, 2);
    run_until(48, 400, "rr_beats");
    for (int k = 0; k < 16; k++) begin
      chk("rr_port", outq[3*k][31:28], k % 8);
      chk("rr_tlast", outq[3*k+2][33], 1);
    end
    for (int i = 0; i < NP; i++) begin
      write_reg(8'd1, 32'(i));
      chk("rr_count", status[15:0], 2);
    end

    // Strict priority: port 2 starves port 5 while it keeps requesting.
    pulse_clr();
    write_reg(8'd0, 32'h8000_00FF);
    write_reg(8'd1, 32'd5);
    start_src(2, 2, 4);
    start_src(5, 2, 4);
    run_until(8, 100, "prio_beats");
    for (int k = 0; k < 4; k++) chk("prio_port2", outq[2*k][31:28], 2);
    chk("prio_cnt5", status[15:0], 0);
    run_until(16, 100, "prio_beats5");
    for (int k = 4; k < 8; k++) chk("prio_port5", outq[2*k][31:28], 5);
    write_reg(8'd0, 32'h0000_00FF);

    // Mask cleared mid-packet: packet completes, the next one is drained.
    pulse_clr();
    write_reg(8'd1, 32'd3);
    start_src(3, 4, 2);
    n = 0;
    while (src_beat[3] != 2 && n < 50) begin tick(); n++; end
    chk("mask_mid", src_beat[3], 2);
    write_reg(8'd0, 32'h0000_00F7);
    chk("mask_busy", status[31], 1);
    chk("mask_grant", status[27:24], 3);
    run_until(4, 50, "mask_beats");
    for (int k = 0; k < 4; k++) begin
      chk("mask_idx", outq[k][15:0], k);
      chk("mask_tlast", outq[k][33], k == 3);
    end
    repeat (20) tick();
    chk("drain_no_out", outq.size(), 4);
    chk("drain_consumed", src_left[3], 0);
    chk("drain_ready", inp_ready[3], 1);
    chk("drain_count", status[15:0], 1);
    write_reg(8'd0, 32'h0000_00FF);

    // Output backpressure toggling every cycle on a 6-beat packet.
    pulse_clr();
    tog = 1'b1;
    start_src(0, 6, 1);
    run_until(6, 80, "bp_beats");
    for (int k = 0; k < 6; k++) begin
      chk("bp_idx", outq[k][15:0], k);
      chk("bp_tlast", outq[k][33], k == 5);
    end
    repeat (10) tick();
    chk("bp_no_dup", outq.size(), 6);
    tog = 1'b0;
    out_ready = 1'b1;

    // Reset mid-packet; ports 4..7 masked beforehand so reset must restore the mask.
    pulse_clr();
    write_reg(8'd0, 32'h0000_000F);
    start_src(1, 5, 1);
    run_until(2, 30, "rstmid_beats");
    src_left[1] = 0;
    rst_n = 1'b0;
    drive();
    tick();
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_out_data", out_data, 0);
    chk("rstmid_status", status, 0);
    rst_n = 1'b1;
    outq.delete();
    start_src(7, 2, 1);
    run_until(2, 30, "rstmid_after");
    chk("rstmid_port", outq[0][31:28], 7);
    chk("rstmid_idx", outq[1][15:0], 1);
    chk("rstmid_tlast", outq[1][33], 1);

    // Counter wrap: 2^CNT_W + 1 single-beat packets on port 4.
    pulse_clr();
    write_reg(8'd1, 32'd4);
    start_src(4, 1, 17);
    run_until(17, 200, "wrap_beats");
    repeat (2) tick();
    chk("wrap_count", status[15:0], 1);
    write_reg(8'd1, 32'd12);
    chk("sel_oob", status[15:0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
